dispatcher_8vie_nbit: RTL and testbench

DISPATCHER_8VIE_NBIT -- requirements
Module: dispatcher_8vie_nbit

---
 rtl/dispatcher_8vie_nbit.sv | 72 +++++++
 tb/tb_dispatcher_8vie_nbit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dispatcher_8vie_nbit.sv
// dispatcher_8vie_nbit: queues requests and issues them one at a time to an 8-way selector, completing each on its way's ack or dropping it on timeout; ports: clock/reset, in_valid/in_data/in_dest/in_ready request side, x/alpha/x_valid/ack selector side, err/err_dest timeout report, level queue occupancy
module dispatcher_8vie_nbit #(
  parameter int N = 31,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [N-1:0]             in_data,
  input  logic [2:0]               in_dest,
  output logic                     in_ready,
  output logic [N-1:0]             x,
  output logic [2:0]               alpha,
  output logic                     x_valid,
  input  logic [7:0]               ack,
  output logic                     err,
  output logic [2:0]               err_dest,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [N+2:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [7:0] cnt;
  logic [N-1:0] x_q;
  logic [2:0] alpha_q;
  logic push, pop, hit, timeout, done;
  assign in_ready = level < FULL;
  assign push = in_valid & in_ready;
  assign hit = state == WAIT && ack[alpha_q];
  // the TIMEOUT-th waiting cycle ends with cnt == TIMEOUT-1; a coincident ack wins
  assign timeout = state == WAIT && !ack[alpha_q] && cnt == TLAST;
  assign done = hit | timeout;
  assign pop = level != '0 && (state == IDLE || done);
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb state_n = pop ? WAIT : done ? IDLE : state;
  always_comb begin
    x_valid = state == WAIT;
    x = x_valid ? x_q : '0;
    alpha = x_valid ? alpha_q : '0;
  end
  always_ff @(posedge clock)
    if (push) mem[wptr] <= {in_data, in_dest};
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      cnt <= '0;
      x_q <= '0;
      alpha_q <= '0;
      err <= 1'b0;
      err_dest <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        {x_q, alpha_q} <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      cnt <= pop ? '0 : state == WAIT ? cnt + 8'd1 : cnt;
      err <= timeout;
      err_dest <= timeout ? alpha_q : '0;
    end
  end
endmodule

// File: tb/tb_dispatcher_8vie_nbit.sv
// tb_dispatcher_8vie_nbit: scoreboard bench for dispatcher_8vie_nbit
module tb_dispatcher_8vie_nbit;
  localparam int N = 31;
  localparam int DEPTH = 4;
  localparam int TO = 6;
  logic clock = 0, reset = 1, in_valid = 0;
  logic [N-1:0] in_data = '0;
  logic [2:0] in_dest = '0;
  logic in_ready, x_valid, err;
  logic [N-1:0] x;
  logic [2:0] alpha, err_dest;
  logic [7:0] ack = '0;
  logic [2:0] level;
  int checks = 0, fails = 0;
  logic [N+2:0] exp_q[$];
  logic prev_valid = 0, prev_hit = 0;
  dispatcher_8vie_nbit #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_dest(in_dest), .in_ready(in_ready), .x(x), .alpha(alpha),
    .x_valid(x_valid), .ack(ack), .err(err), .err_dest(err_dest), .level(level)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic push(input logic [N-1:0] d, input logic [2:0] dst, input logic accept);
    in_valid = 1;
    in_data = d;
    in_dest = dst;
    chk("in_ready", in_ready, accept);
    if (accept) exp_q.push_back({d, dst});
    tick;
    in_valid = 0;
  endtask
  always @(negedge clock) begin
    logic [N+2:0] e;
    if (reset) begin
      prev_valid = 0;
      prev_hit = 0;
    end else begin
      if (x_valid && (!prev_valid || prev_hit || err)) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL dispatch: got x=%0h alpha=%0d expected no dispatch", x, alpha);
        end else begin
          e = exp_q.pop_front();
          chk("disp_x", x, e[N+2:3]);
          chk("disp_alpha", alpha, e[2:0]);
        end
      end
      if (!x_valid) begin
        chk("idle_x", x, 0);
        chk("idle_alpha", alpha, 0);
      end
      if (!err) chk("err_dest_idle", err_dest, 0);
      prev_valid = x_valid;
      prev_hit = x_valid && ack[alpha];
    end
  end
  initial begin
    tick;
    tick;
    reset = 0;
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_x_valid", x_valid, 0);
    chk("rst_x", x, 0);
    chk("rst_err", err, 0);
    push(31'h1234, 3'd5, 1);
    chk("lat_level", level, 1);
    chk("lat_valid0", x_valid, 0);
    tick;
    chk("lat_valid1", x_valid, 1);
    chk("lat_x", x, 32'h1234);
    chk("lat_alpha", alpha, 5);
    chk("lat_level0", level, 0);
    ack = 8'h20;
    tick;
    ack = 0;
    chk("ack_valid", x_valid, 0);
    chk("ack_level", level, 0);
    push(31'h70, 3'd7, 1);
    for (int i = 0; i < 4; i++) push(31'hA0 + 31'(i), 3'(i), 1);
    chk("full_level", level, 4);
    chk("full_alpha", alpha, 7);
    in_valid = 1;
    in_data = 31'hB4;
    in_dest = 3'd4;
    ack = 8'h80;
    chk("full_ready", in_ready, 0);
    tick;
    in_valid = 0;
    chk("full_pp_level", level, 3);
    chk("full_pp_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_valid", x_valid, 1);
      chk("b2b_alpha", alpha, 3'(i));
      ack = 8'(1 << i);
      tick;
    end
    ack = 0;
    chk("b2b_end_valid", x_valid, 0);
    chk("b2b_end_level", level, 0);
    push(31'hC2, 3'd2, 1);
    push(31'hC3, 3'd3, 1);
    ack = 8'h40;
    chk("to_alpha", alpha, 2);
    for (int i = 0; i < TO - 1; i++) begin
      tick;
      chk("to_wait_err", err, 0);
      chk("to_wait_alpha", alpha, 2);
    end
    tick;
    chk("to_err", err, 1);
    chk("to_err_dest", err_dest, 2);
    chk("to_next_alpha", alpha, 3);
    ack = 8'h08;
    tick;
    ack = 0;
    chk("to_pulse_end", err, 0);
    chk("to_done_valid", x_valid, 0);
    push(31'hD4, 3'd4, 1);
    tick;
    repeat (TO) tick;
    chk("toi_err", err, 1);
    chk("toi_err_dest", err_dest, 4);
    chk("toi_valid", x_valid, 0);
    tick;
    chk("toi_pulse_end", err, 0);
    push(31'hE1, 3'd1, 1);
    tick;
    repeat (TO - 1) tick;
    ack = 8'h02;
    tick;
    ack = 0;
    chk("tie_err", err, 0);
    chk("tie_valid", x_valid, 0);
    tick;
    chk("tie_err_later", err, 0);
    for (int i = 0; i < 4; i++) push(31'hF0 + 31'(i), 3'(i), 1);
    chk("prerst_level", level, 3);
    chk("prerst_valid", x_valid, 1);
    reset = 1;
    ack = 8'hFF;
    in_valid = 1;
    exp_q.delete();
    tick;
    reset = 0;
    ack = 0;
    in_valid = 0;
    chk("mrst_level", level, 0);
    chk("mrst_valid", x_valid, 0);
    chk("mrst_x", x, 0);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_err", err, 0);
    push(31'h55, 3'd6, 1);
    tick;
    ack = 8'h40;
    tick;
    ack = 0;
    chk("post_valid", x_valid, 0);
    tick;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
